// File: rtl/spi_gyro_responder.sv
// SPI mode-3 slave emulating the Pmod three-axis gyro register file.
// All SPI pins are oversampled in the CLK domain.
module spi_gyro_responder #(
    parameter logic [7:0] WHO_AM_I  = 8'hD3,
    parameter logic [7:0] CTRL1_RST = 8'h07
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS,
    output logic        MISO,
    input  logic [15:0] X_IN,
    input  logic [15:0] Y_IN,
    input  logic [15:0] Z_IN,
    input  logic        SAMPLE_VALID,
    output logic [7:0]  CTRL1,
    output logic        WR_STROBE
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA_RD,
        DATA_WR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sclk_sync_q;
    logic [2:0]      ss_sync_q;
    logic [1:0]      mosi_sync_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      tx_q, tx_d;
    logic [5:0]      addr_q, addr_d;
    logic            ms_q, ms_d;
    logic            miso_q, miso_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [4:0][7:0] ctrl_q, ctrl_d;
    logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [15:0]     px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic            pend_q, pend_d;
    logic            zyxda_q, zyxda_d;

    logic       ss_hi, ss_rise, ss_fall;
    logic       sck_rise, sck_fall;
    logic [7:0] byte_in;
    logic [5:0] fetch_addr;
    logic [7:0] rd_data;
    logic       z_clr;
    logic       load;

    assign ss_hi    = ss_sync_q[1];
    assign ss_rise  = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_fall  = ~ss_sync_q[1] & ss_sync_q[2];
    assign sck_rise = sclk_sync_q[1] & ~sclk_sync_q[2] & ~ss_rise & ~ss_fall;
    assign sck_fall = ~sclk_sync_q[1] & sclk_sync_q[2] & ~ss_rise & ~ss_fall;
    assign byte_in  = {shift_q[6:0], mosi_sync_q[1]};

    assign fetch_addr = (state_q == CMD) ? byte_in[5:0] : addr_q;

    always_comb begin
        rd_data = 8'h00;
        case (fetch_addr)
            6'h0F: rd_data = WHO_AM_I;
            6'h20: rd_data = ctrl_q[0];
            6'h21: rd_data = ctrl_q[1];
            6'h22: rd_data = ctrl_q[2];
            6'h23: rd_data = ctrl_q[3];
            6'h24: rd_data = ctrl_q[4];
            6'h27: rd_data = {4'b0, zyxda_q, 3'b0};
            6'h28: rd_data = x_q[7:0];
            6'h29: rd_data = x_q[15:8];
            6'h2A: rd_data = y_q[7:0];
            6'h2B: rd_data = y_q[15:8];
            6'h2C: rd_data = z_q[7:0];
            6'h2D: rd_data = z_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        ms_d        = ms_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        ctrl_d      = ctrl_q;
        z_clr       = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ms_d = byte_in[6];
                        if (byte_in[7]) begin
                            state_d = DATA_RD;
                            tx_d    = rd_data;
                            addr_d  = byte_in[5:0] + {5'b0, byte_in[6]};
                            z_clr   = (byte_in[5:0] == 6'h2D);
                        end else begin
                            state_d = DATA_WR;
                            addr_d  = byte_in[5:0];
                        end
                    end
                end
            end
            DATA_RD: begin
                if (sck_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d   = rd_data;
                        addr_d = addr_q + {5'b0, ms_q};
                        z_clr  = (addr_q == 6'h2D);
                    end
                end else if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            DATA_WR: begin
                if (sck_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d      = addr_q + {5'b0, ms_q};
                        wr_strobe_d = 1'b1;
                        case (addr_q)
                            6'h20: ctrl_d[0] = byte_in;
                            6'h21: ctrl_d[1] = byte_in;
                            6'h22: ctrl_d[2] = byte_in;
                            6'h23: ctrl_d[3] = byte_in;
                            6'h24: ctrl_d[4] = byte_in;
                            default: wr_strobe_d = 1'b0;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a partial byte is dropped simply by never reaching bit 7
        if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        px_d   = px_q;
        py_d   = py_q;
        pz_d   = pz_q;
        pend_d = pend_q;
        load   = 1'b0;
        if (ss_hi) begin
            if (SAMPLE_VALID) begin
                x_d  = X_IN;
                y_d  = Y_IN;
                z_d  = Z_IN;
                load = 1'b1;
            end else if (pend_q) begin
                x_d  = px_q;
                y_d  = py_q;
                z_d  = pz_q;
                load = 1'b1;
            end
            pend_d = 1'b0;
        end else if (SAMPLE_VALID) begin
            // hold the sample back so a burst in flight never tears
            px_d   = X_IN;
            py_d   = Y_IN;
            pz_d   = Z_IN;
            pend_d = 1'b1;
        end
        zyxda_d = load | (zyxda_q & ~(z_clr & ~SAMPLE_VALID));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sclk_sync_q <= 3'b111;
            // SS sync resets low so a frame already in progress is ignored
            ss_sync_q   <= 3'b000;
            mosi_sync_q <= 2'b00;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 6'h00;
            ms_q        <= 1'b0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            ctrl_q      <= {8'h00, 8'h00, 8'h00, 8'h00, CTRL1_RST};
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            z_q         <= 16'h0000;
            px_q        <= 16'h0000;
            py_q        <= 16'h0000;
            pz_q        <= 16'h0000;
            pend_q      <= 1'b0;
            zyxda_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            ss_sync_q   <= {ss_sync_q[1:0], SS};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            ms_q        <= ms_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            ctrl_q      <= ctrl_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pz_q        <= pz_d;
            pend_q      <= pend_d;
            zyxda_q     <= zyxda_d;
        end
    end

    assign MISO      = miso_q & ~SS;
    assign CTRL1     = ctrl_q[0];
    assign WR_STROBE = wr_strobe_q;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Scoreboard bench for spi_gyro_responder: a mode-3 SPI master
// queues expected bytes/writes; monitors pop and compare.
module tb_spi_gyro_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SCLK, MOSI, SS, MISO, SAMPLE_VALID, WR_STROBE;
    logic [15:0] X_IN, Y_IN, Z_IN;
    logic [7:0]  CTRL1;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rx_byte;
    event       rx_ev;

    spi_gyro_responder dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .SS          (SS),
        .MISO        (MISO),
        .X_IN        (X_IN),
        .Y_IN        (Y_IN),
        .Z_IN        (Z_IN),
        .SAMPLE_VALID(SAMPLE_VALID),
        .CTRL1       (CTRL1),
        .WR_STROBE   (WR_STROBE)
    );

    always #5 CLK = ~CLK;

    // received-byte monitor
    initial begin
        logic [7:0] exp;
        forever begin
            @(rx_ev);
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_extra got %02h expected none", rx_byte);
            end else begin
                exp = rx_q.pop_front();
                if (rx_byte !== exp) begin
                    errors++;
                    $display("FAIL rx_byte got %02h expected %02h", rx_byte, exp);
                end
            end
        end
    end

    // write-strobe monitor
    always @(negedge CLK) begin
        logic [7:0] exp;
        if (WR_STROBE === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_extra strobe with CTRL1 %02h expected none", CTRL1);
            end else begin
                exp = wr_q.pop_front();
                if (CTRL1 !== exp) begin
                    errors++;
                    $display("FAIL wr_ctrl1 got %02h expected %02h", CTRL1, exp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic frame(input int n, input bit rd, input int abort_bits,
                         input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                         input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                         input logic [7:0] b4 = 8'h00, input logic [7:0] b5 = 8'h00,
                         input logic [7:0] b6 = 8'h00);
        logic [7:0] b [8];
        logic [7:0] r;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        b[4] = b4; b[5] = b5; b[6] = b6; b[7] = 8'h00;
        @(negedge CLK);
        SS = 1'b0;
        repeat (6) @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            r = 8'h00;
            for (int k = 7; k >= 0; k--) begin
                SCLK = 1'b0;
                MOSI = b[i][k];
                repeat (5) @(negedge CLK);
                r = {r[6:0], MISO};
                SCLK = 1'b1;
                repeat (5) @(negedge CLK);
            end
            if (rd && i > 0) begin
                rx_byte = r;
                ->rx_ev;
            end
        end
        for (int k = 7; k > 7 - abort_bits; k--) begin
            SCLK = 1'b0;
            MOSI = b[n][k];
            repeat (5) @(negedge CLK);
            SCLK = 1'b1;
            repeat (5) @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        SS = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
        X_IN = x;
        Y_IN = y;
        Z_IN = z;
        SAMPLE_VALID = 1'b1;
        @(negedge CLK);
        SAMPLE_VALID = 1'b0;
    endtask

    initial begin
        SCLK = 1'b1;
        MOSI = 1'b0;
        SS = 1'b1;
        SAMPLE_VALID = 1'b0;
        X_IN = 16'h0;
        Y_IN = 16'h0;
        Z_IN = 16'h0;
        #2 RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("reset_miso", {15'd0, MISO}, 16'h0);
        check("reset_ctrl1", {8'd0, CTRL1}, 16'h07);
        check("reset_wr_strobe", {15'd0, WR_STROBE}, 16'h0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        rx_q.push_back(8'hD3);
        frame(2, 1, 0, 8'h8F);

        wr_q.push_back(8'h0F);
        frame(2, 0, 0, 8'h20, 8'h0F);
        check("ctrl1_after_write", {8'd0, CTRL1}, 16'h0F);
        rx_q.push_back(8'h0F);
        frame(2, 1, 0, 8'hA0);

        wr_q.push_back(8'hAA);
        wr_q.push_back(8'hAA);
        frame(3, 0, 0, 8'h60, 8'hAA, 8'hBB);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        frame(3, 1, 0, 8'hE0);

        pulse_sample(16'h1234, 16'hABCD, 16'h8001);
        repeat (4) @(negedge CLK);
        rx_q.push_back(8'h08);
        frame(2, 1, 0, 8'hA7);
        foreach (rx_q[i]) ;
        rx_q.push_back(8'h34); rx_q.push_back(8'h12);
        rx_q.push_back(8'hCD); rx_q.push_back(8'hAB);
        rx_q.push_back(8'h01); rx_q.push_back(8'h80);
        frame(7, 1, 0, 8'hE8);
        rx_q.push_back(8'h00);
        frame(2, 1, 0, 8'hA7);

        rx_q.push_back(8'h34); rx_q.push_back(8'h12);
        rx_q.push_back(8'hCD); rx_q.push_back(8'hAB);
        rx_q.push_back(8'h01); rx_q.push_back(8'h80);
        fork
            frame(7, 1, 0, 8'hE8);
            begin
                repeat (200) @(negedge CLK);
                pulse_sample(16'h5566, 16'h7788, 16'h99AA);
            end
        join
        rx_q.push_back(8'h08);
        frame(2, 1, 0, 8'hA7);
        rx_q.push_back(8'h66); rx_q.push_back(8'h55);
        rx_q.push_back(8'h88); rx_q.push_back(8'h77);
        rx_q.push_back(8'hAA); rx_q.push_back(8'h99);
        frame(7, 1, 0, 8'hE8);

        frame(1, 0, 4, 8'h20, 8'h55);
        check("ctrl1_after_abort", {8'd0, CTRL1}, 16'hAA);
        frame(3, 0, 0, 8'h7F, 8'h11, 8'h22);
        check("ctrl1_after_wrap", {8'd0, CTRL1}, 16'hAA);
        rx_q.push_back(8'h00);
        frame(2, 1, 0, 8'h80);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        frame(3, 1, 0, 8'hE0);

        repeat (50) @(negedge CLK);
        check("rx_queue_drained", 16'(rx_q.size()), 16'h0);
        check("wr_queue_drained", 16'(wr_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
